// File: rtl/mips_dmem_pkg.sv
// Shared definitions for the MIPS data-memory arbiter.
//   - default address/data widths
//   - arbiter FSM state encoding
//   - one-hot grant encoding (bit0 CPU, bit1 loader) and requester indices
package mips_dmem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_LDR  = 2'b10;

  localparam int REQ_CPU = 0;
  localparam int REQ_LDR = 1;

endpackage

// File: rtl/mips_dmem_arb_pick.sv
// Combinational requester select for the data-memory arbiter.
// Ports:
//   req      [1:0] in   request vector, bit0 CPU, bit1 loader
//   prio_ldr       in   (DMEM_ARB_RR_EN only) loader has priority on contention
//   pick     [1:0] out  one-hot winner, 00 when nobody requests
// Build option: DMEM_ARB_RR_EN selects round-robin; default is fixed
// priority with the CPU always winning on contention.
module mips_dmem_arb_pick
  import mips_dmem_pkg::*;
(
  input  logic [1:0] req,
`ifdef DMEM_ARB_RR_EN
  input  logic       prio_ldr,
`endif
  output logic [1:0] pick
);

  always_comb begin
    pick = GNT_NONE;
`ifdef DMEM_ARB_RR_EN
    // With a single requester the request vector already is the one-hot grant.
    if (req == 2'b11) pick = prio_ldr ? GNT_LDR : GNT_CPU;
    else              pick = req;
`else
    if (req[REQ_CPU])      pick = GNT_CPU;
    else if (req[REQ_LDR]) pick = GNT_LDR;
`endif
  end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// Two-requester arbiter (CPU data port, program/debug loader) in front of a
// single data memory with one-cycle read latency.
// FSM: IDLE (arbitrate, latch winner's request) -> ACCESS (one memory strobe)
//      -> RESP (reads only, return mem_readdata) -> IDLE.
// Ports:
//   clk, reset (sync, active high), clk_enable (low freezes all state and
//     silences memory strobes)
//   cpu_*  : address/writedata/read/write in, readdata/waitrequest out
//   ldr_*  : same for the loader
//   mem_*  : address/writedata/read/write out, readdata in
//   grant  : one-hot owner (bit0 CPU, bit1 loader), 00 while idle
//   err    : sticky, set when a winner strobes read and write together
// Build option: DMEM_ARB_RR_EN enables round-robin arbitration.
module mips_dmem_arbiter
  import mips_dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  input  logic [ADDR_W-1:0] ldr_address,
  input  logic [DATA_W-1:0] ldr_writedata,
  input  logic              ldr_read,
  input  logic              ldr_write,
  output logic [DATA_W-1:0] ldr_readdata,
  output logic              ldr_waitrequest,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [1:0]        grant,
  output logic              err
);

  arb_state_t        state;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_wr;
  logic [DATA_W-1:0] cpu_rd_q, ldr_rd_q;

  logic [1:0]        req, pick;
  logic              sel_ldr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_read, win_write;

  assign req = {ldr_read | ldr_write, cpu_read | cpu_write};

`ifdef DMEM_ARB_RR_EN
  // Set when the loader should win the next contention (CPU was granted last).
  logic prio_ldr;

  mips_dmem_arb_pick u_pick (
    .req      (req),
    .prio_ldr (prio_ldr),
    .pick     (pick)
  );
`else
  mips_dmem_arb_pick u_pick (
    .req  (req),
    .pick (pick)
  );
`endif

  assign sel_ldr   = (pick == GNT_LDR);
  assign win_addr  = sel_ldr ? ldr_address   : cpu_address;
  assign win_wdata = sel_ldr ? ldr_writedata : cpu_writedata;
  assign win_read  = sel_ldr ? ldr_read      : cpu_read;
  assign win_write = sel_ldr ? ldr_write     : cpu_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= GNT_NONE;
      err       <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
      cpu_rd_q  <= '0;
      ldr_rd_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      prio_ldr  <= 1'b0;
`endif
    end else if (clk_enable) begin
      unique case (state)
        IDLE: begin
          if (pick != GNT_NONE) begin
            grant     <= pick;
            // Request is captured here so the winner may drop its strobes early.
            lat_addr  <= win_addr;
            lat_wdata <= win_wdata;
            // Write takes precedence when both strobes are up; flag the misuse.
            lat_wr    <= win_write;
            if (win_write && win_read) err <= 1'b1;
`ifdef DMEM_ARB_RR_EN
            prio_ldr  <= (pick == GNT_CPU);
`endif
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_wr) begin
            grant <= GNT_NONE;
            state <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          if (grant == GNT_CPU) cpu_rd_q <= mem_readdata;
          else                  ldr_rd_q <= mem_readdata;
          grant <= GNT_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated so a frozen or resetting arbiter neither strobes memory
  // nor completes a requester's transfer.
  logic active, done;
  assign active = clk_enable && !reset;
  assign done   = active && ((state == ACCESS && lat_wr) || state == RESP);

  assign mem_address   = lat_addr;
  assign mem_writedata = lat_wdata;
  assign mem_write     = active && (state == ACCESS) &&  lat_wr;
  assign mem_read      = active && (state == ACCESS) && !lat_wr;

  assign cpu_waitrequest = !(done && grant == GNT_CPU);
  assign ldr_waitrequest = !(done && grant == GNT_LDR);

  // Read data flows straight through in RESP; otherwise each port holds the
  // last value it was returned.
  assign cpu_readdata = (active && state == RESP && grant == GNT_CPU) ? mem_readdata : cpu_rd_q;
  assign ldr_readdata = (active && state == RESP && grant == GNT_LDR) ? mem_readdata : ldr_rd_q;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
module tb_mips_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset, clk_enable;
  logic [31:0] cpu_address, cpu_writedata, cpu_readdata;
  logic        cpu_read, cpu_write, cpu_waitrequest;
  logic [31:0] ldr_address, ldr_writedata, ldr_readdata;
  logic        ldr_read, ldr_write, ldr_waitrequest;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write;
  logic [1:0]  grant;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_mem_wr = 0, n_mem_rd = 0, n_ldr_over_cpu = 0;
  bit mon_on = 0;

  logic [31:0] dmem    [0:255];   // memory behind the arbiter
  logic [31:0] ref_mem [0:255];   // expected memory contents

  always #5 clk = ~clk;

  mips_dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
    .ldr_address(ldr_address), .ldr_writedata(ldr_writedata),
    .ldr_read(ldr_read), .ldr_write(ldr_write),
    .ldr_readdata(ldr_readdata), .ldr_waitrequest(ldr_waitrequest),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_readdata(mem_readdata),
    .grant(grant), .err(err)
  );

  // Memory: read data valid the cycle after mem_read.
  always @(posedge clk) begin
    if (mem_write) dmem[mem_address[7:0]] <= mem_writedata;
    if (mem_read)  mem_readdata <= dmem[mem_address[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Per-cycle rules that must hold whatever the traffic.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("mem_excl", {31'd0, mem_read & mem_write}, 32'd0);
      chk("grant_onehot", {31'd0, $countones(grant) <= 1}, 32'd1);
      if (!clk_enable) chk("ce_strobe_low", {31'd0, mem_read | mem_write}, 32'd0);
      if ((cpu_read | cpu_write) && grant != 2'b01) chk("cpu_wait_not_granted", {31'd0, cpu_waitrequest}, 32'd1);
      if ((ldr_read | ldr_write) && grant != 2'b10) chk("ldr_wait_not_granted", {31'd0, ldr_waitrequest}, 32'd1);
      if (mem_write) n_mem_wr++;
      if (mem_read)  n_mem_rd++;
      if (grant == 2'b10 && cpu_read) n_ldr_over_cpu++;
    end
  end

  // Drive one request (called just after a rising edge), hold it until
  // waitrequest is seen low, then drop it after the next rising edge.
  // lat counts sampled cycles from strobe assertion to completion.
  task automatic xfer(input bit ldr, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, output int lat, output logic [31:0] rdata);
    bit got = 0;
    lat = -1;
    rdata = 'x;
    if (ldr) begin ldr_address = addr; ldr_writedata = data; ldr_read = rd; ldr_write = wr; end
    else     begin cpu_address = addr; cpu_writedata = data; cpu_read = rd; cpu_write = wr; end
    if (wr) ref_mem[addr[7:0]] = data;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      if (!(ldr ? ldr_waitrequest : cpu_waitrequest)) begin
        got = 1;
        lat = i;
        rdata = ldr ? ldr_readdata : cpu_readdata;
      end
    end
    @(posedge clk); #1;
    if (ldr) begin ldr_read = 0; ldr_write = 0; end
    else     begin cpu_read = 0; cpu_write = 0; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, lat_c, lat_l, w0, r0, g0;
    logic [31:0] rd, rd_c, rd_l;
    for (int i = 0; i < 256; i++) begin dmem[i] = 32'd0; ref_mem[i] = 32'd0; end
    mem_readdata = 0;
    reset = 1; clk_enable = 1;
    cpu_address = 0; cpu_writedata = 0; cpu_read = 0; cpu_write = 0;
    ldr_address = 0; ldr_writedata = 0; ldr_read = 0; ldr_write = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cpu_wait", {31'd0, cpu_waitrequest}, 32'd1);
    chk("rst_ldr_wait", {31'd0, ldr_waitrequest}, 32'd1);
    chk("rst_cpu_rdata", cpu_readdata, 32'd0);
    chk("rst_ldr_rdata", ldr_readdata, 32'd0);
    chk("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    mon_on = 1;

    // CPU write then back-to-back read of the same word.
    w0 = n_mem_wr;
    xfer(0, 0, 1, 32'h10, 32'h0000FFF0, lat, rd);
    chk("wr_latency", lat, 32'd2);
    chk("wr_one_strobe", n_mem_wr - w0, 32'd1);
    xfer(0, 1, 0, 32'h10, 32'h0, lat, rd);
    chk("rd_latency", lat, 32'd3);
    chk("rd_data_lit", rd, 32'h0000FFF0);
    chk("rd_data_model", rd, ref_mem[8'h10]);

    // Loader write: makes the loader the most recent owner.
    xfer(1, 0, 1, 32'h14, 32'h00001234, lat, rd);
    chk("ldr_wr_latency", lat, 32'd2);

    // Simultaneous reads: CPU first in both arbitration modes.
    fork
      xfer(0, 1, 0, 32'h10, 32'h0, lat_c, rd_c);
      xfer(1, 1, 0, 32'h14, 32'h0, lat_l, rd_l);
      begin
        @(negedge clk); chk("cont_ldr_wait1", {31'd0, ldr_waitrequest}, 32'd1);
        @(negedge clk); chk("cont_grant_cpu", {30'd0, grant}, 32'd1);
                        chk("cont_ldr_wait2", {31'd0, ldr_waitrequest}, 32'd1);
        @(negedge clk); chk("cont_ldr_wait3", {31'd0, ldr_waitrequest}, 32'd1);
      end
    join
    chk("cont_cpu_lat", lat_c, 32'd3);
    chk("cont_cpu_data", rd_c, ref_mem[8'h10]);
    chk("cont_ldr_lat", lat_l, 32'd6);
    chk("cont_ldr_data", rd_l, 32'h00001234);
    @(negedge clk);
    chk("cpu_rdata_hold", cpu_readdata, 32'h0000FFF0);
    @(posedge clk); #1;

    // Continuous CPU reads with a pending loader write.
    g0 = n_ldr_over_cpu;
    fork
      begin
        int l;
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
          xfer(0, 1, 0, 32'h10, 32'h0, l, r);
          chk("stream_cpu_data", r, 32'h0000FFF0);
`ifndef DMEM_ARB_RR_EN
          chk("stream_cpu_lat", l, 32'd3);
`endif
        end
      end
      xfer(1, 0, 1, 32'h18, 32'h0BADF00D, lat_l, rd_l);
    join
`ifdef DMEM_ARB_RR_EN
    chk("rr_ldr_lat", lat_l, 32'd5);
    chk("rr_ldr_granted", {31'd0, n_ldr_over_cpu > g0}, 32'd1);
`else
    chk("fixed_ldr_lat", lat_l, 32'd14);
    chk("fixed_no_ldr_grant", n_ldr_over_cpu - g0, 32'd0);
`endif
    xfer(0, 1, 0, 32'h18, 32'h0, lat, rd);
    chk("stream_ldr_write_data", rd, 32'h0BADF00D);
    chk("err_still_clear", {31'd0, err}, 32'd0);

    // Loader read+write together: write wins, err sticks.
    r0 = n_mem_rd;
    xfer(1, 1, 1, 32'h20, 32'hA5A50020, lat, rd);
    chk("rw_lat", lat, 32'd2);
    chk("rw_no_read", n_mem_rd - r0, 32'd0);
    chk("rw_err_set", {31'd0, err}, 32'd1);
    xfer(0, 1, 0, 32'h20, 32'h0, lat, rd);
    chk("rw_data", rd, ref_mem[8'h20]);
    chk("rw_data_lit", rd, 32'hA5A50020);
    chk("rw_err_sticky", {31'd0, err}, 32'd1);

    // Reset while a CPU read sits in RESP.
    cpu_address = 32'h10; cpu_read = 1;
    @(negedge clk);
    @(negedge clk); chk("rstresp_access", {31'd0, mem_read}, 32'd1);
    @(posedge clk); #1; reset = 1;
    @(negedge clk); chk("rstresp_no_complete", {31'd0, cpu_waitrequest}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstresp_grant", {30'd0, grant}, 32'd0);
    chk("rstresp_cpu_wait", {31'd0, cpu_waitrequest}, 32'd1);
    chk("rstresp_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rstresp_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1; reset = 0; cpu_read = 0;
    @(negedge clk);
    chk("rstresp_strobes2", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rstresp_rdata", cpu_readdata, 32'd0);
    @(posedge clk); #1;

    // Freeze during ACCESS; request inputs change meanwhile.
    cpu_address = 32'h30; cpu_writedata = 32'hDEAD0031; cpu_write = 1;
    ref_mem[8'h30] = 32'hDEAD0031;
    @(negedge clk); chk("ce_idle_wait", {31'd0, cpu_waitrequest}, 32'd1);
    @(posedge clk); #1;
    clk_enable = 0;
    cpu_address = 32'h99; cpu_writedata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ce_frozen_wr", {31'd0, mem_write}, 32'd0);
      chk("ce_frozen_wait", {31'd0, cpu_waitrequest}, 32'd1);
      chk("ce_frozen_grant", {30'd0, grant}, 32'd1);
      @(posedge clk);
    end
    #1 clk_enable = 1;
    @(negedge clk);
    chk("ce_resume_wr", {31'd0, mem_write}, 32'd1);
    chk("ce_resume_addr", mem_address, 32'h30);
    chk("ce_resume_data", mem_writedata, 32'hDEAD0031);
    chk("ce_resume_done", {31'd0, cpu_waitrequest}, 32'd0);
    @(posedge clk); #1; cpu_write = 0;
    xfer(0, 1, 0, 32'h30, 32'h0, lat, rd);
    chk("ce_readback", rd, ref_mem[8'h30]);
    chk("ce_readback_lat", lat, 32'd3);

    repeat (2) @(posedge clk);
    mon_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_dmem_arbiter.md
MIPS_DMEM_ARBITER -- requirements
Module: mips_dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width on all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width on all ports.
REQ-003 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port clk_enable  input  1  when low, all state SHALL freeze and memory strobes SHALL be driven low.
REQ-006 Ports cpu_address/cpu_writedata  input  ADDR_W/DATA_W  CPU data-port request address and store data.
REQ-007 Ports cpu_read, cpu_write  input  1 each  CPU request strobes, held until the cycle in which cpu_waitrequest is low.
REQ-008 Ports cpu_readdata  output  DATA_W; cpu_waitrequest  output  1  CPU response data and stall.
REQ-009 Ports ldr_address, ldr_writedata, ldr_read, ldr_write, ldr_readdata, ldr_waitrequest SHALL mirror REQ-006..008 for the program/debug loader requester.
REQ-010 Ports mem_address, mem_writedata, mem_read, mem_write  output; mem_readdata  input  DATA_W  shared data memory; read data valid exactly one cycle after mem_read.
REQ-011 Port grant  output  2  one-hot current owner, bit0 CPU, bit1 loader; port err  output  1  sticky protocol error.

Function
REQ-012 FSM states SHALL be IDLE, ACCESS, RESP; arbitration SHALL occur only in IDLE.
REQ-013 IDLE: if any requester strobes, latch winner into grant and go to ACCESS; else stay, grant = 00.
REQ-014 ACCESS: drive winner's address/data/strobe to memory for exactly one cycle; write -> winner waitrequest low this cycle, next state IDLE; read -> next state RESP.
REQ-015 RESP: mem_readdata SHALL pass to winner's readdata with winner waitrequest low; next state IDLE.
REQ-016 Latency: write completes 2 cycles after strobe seen in IDLE; read completes 3 cycles; back-to-back from one requester SHALL pass through IDLE between accesses.
REQ-017 Non-granted requester's waitrequest SHALL be high whenever its strobe is high; readdata of non-granted port SHALL hold last value.
REQ-018 Read and write both high on winning requester: write SHALL be performed, read dropped, err set until reset.
REQ-019 Strobes deasserted by winner while in ACCESS/RESP: transaction SHALL complete with latched values (address/data latched on grant).
REQ-020 mem_read and mem_write SHALL never be high simultaneously and SHALL be low outside ACCESS.

Reset
REQ-021 Reset SHALL force state IDLE, grant 00, err 0, mem strobes 0, both waitrequest 1, both readdata 0, priority pointer to CPU; an in-flight transaction SHALL be abandoned without a memory strobe the following cycle.

Configuration
REQ-022 With DMEM_ARB_RR_EN defined, IDLE arbitration SHALL be round-robin: on contention the requester not granted last SHALL win.
REQ-023 Without DMEM_ARB_RR_EN, arbitration SHALL be fixed priority, CPU always winning on contention; priority pointer logic SHALL be absent.

Structure
REQ-024 A shared package mips_dmem_pkg SHALL hold the FSM state enum, grant encoding constants and DATA_W/ADDR_W defaults.
REQ-025 One sub-module mips_dmem_arb_pick (combinational requester select, fixed or round-robin per macro) SHALL be instantiated; FSM and muxing remain in the top.

Verification
REQ-026 CPU write 0x0000FFF0 to 0x10, then CPU read 0x10 -> mem_write one cycle at cycle 1, read completes cycle 3 with cpu_readdata = 0x0000FFF0.
REQ-027 CPU and loader read simultaneously (fixed priority) -> grant 01 first, loader waitrequest high for 3 cycles, loader served next; with DMEM_ARB_RR_EN and loader granted last, CPU first regardless.
REQ-028 Continuous CPU reads, loader write pending, DMEM_ARB_RR_EN defined -> loader granted within 4 cycles; without macro loader starves (check grant never 10).
REQ-029 Loader asserts read and write together at 0x20 -> write performed, err = 1 and stays 1 until reset.
REQ-030 Reset asserted in RESP of CPU read -> next cycle state IDLE, cpu_waitrequest 1, mem strobes 0, grant 00.
REQ-031 clk_enable low for 5 cycles during ACCESS -> no state change, mem strobes low; resume completes transaction with correct data.
